// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: controller states,
// hex glyph table and the output polarity helper.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

  // Converts a logical "asserted" bit into the pin level.
  function automatic logic drive_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle,
// keeping only the low DIGITS BCD digits and flagging anything lost.
module bin2bcd_seq #(
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  shreg;
  logic [W-1:0]  adj;
  logic [CW-1:0] steps_left;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bcd        <= '0;
      steps_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        shreg      <= bin;
        bcd        <= '0;
        steps_left <= CW'(W);
        busy       <= 1'b1;
        overflow   <= 1'b0;
      end else if (busy) begin
        // adj[W-1] is the bit that falls off the top kept digit
        bcd        <= {adj[W-2:0], shreg[W-1]};
        shreg      <= {shreg[W-2:0], 1'b0};
        steps_left <= steps_left - CW'(1);
        if (adj[W-1]) overflow <= 1'b1;
        if (steps_left == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with hex or decimal display register.
//   state     | meaning
//   ST_IDLE   | ready for load; hex loads complete here
//   ST_CONV   | binary-to-BCD conversion running, old display still scanned
//   ST_COMMIT | BCD result and overflow written to display register
module seg_scan_display import seg_pkg::*; #(
  parameter int DIGITS     = 8,
  parameter int CLK_DIV    = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  ready,
  output logic                  overflow,
  output logic [DIGITS-1:0]     anode,
  output logic [7:0]            cathode
);

  localparam int   W     = 4 * DIGITS;
  localparam int   PRE_W = $clog2(CLK_DIV);
  localparam int   IDX_W = $clog2(DIGITS);
  localparam logic AL    = (ACTIVE_LOW != 0);

  scan_state_t state_q, state_d;

  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic             tick;
  logic [W-1:0]     disp;

  logic             conv_start, conv_busy, conv_done, conv_ovf;
  logic [W-1:0]     conv_bcd;
  logic             load_hex, commit;

  logic [3:0]        nib;
  logic              dp_bit, blank, any_nz;
  logic [DIGITS-1:0] sel, anode_d;
  logic [7:0]        seg_on, cathode_d;

  bin2bcd_seq #(.DIGITS(DIGITS)) u_bin2bcd (
    .clock    (clock),
    .reset    (reset),
    .start    (conv_start),
    .bin      (value),
    .busy     (conv_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load && mode) state_d = ST_CONV;
      ST_CONV:   if (conv_done)    state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == ST_IDLE);
    conv_start = ready && load && mode && !conv_busy;
    load_hex   = ready && load && !mode;
    commit     = (state_q == ST_COMMIT);
  end

  assign tick = (pre == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else if (load_hex) begin
      disp     <= value;
      overflow <= 1'b0;
    end else if (commit) begin
      disp     <= conv_bcd;
      overflow <= conv_ovf;
    end
  end

  // Walk from the top digit down so any_nz means "this or a higher nibble is nonzero".
  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    sel    = '0;
    blank  = 1'b0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (|disp[4*i +: 4]);
      if (idx == IDX_W'(i)) begin
        nib    = disp[4*i +: 4];
        dp_bit = dp_mask[i];
        sel[i] = 1'b1;
        blank  = lz_en && (i != 0) && !any_nz;
      end
    end
    seg_on = blank ? 8'h00 : {dp_bit, hex_to_seg(nib)};
    for (int i = 0; i < DIGITS; i++) anode_d[i] = drive_level(sel[i] && !blank, AL);
    for (int b = 0; b < 8; b++)      cathode_d[b] = drive_level(seg_on[b], AL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode   <= {DIGITS{AL}};
      cathode <= {8{AL}};
    end else begin
      anode   <= anode_d;
      cathode <= cathode_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed scenarios plus random loads, checked
// cycle by cycle against a digit-position / decimal-arithmetic model.
module tb_seg_scan_display;

  localparam int DIGITS  = 8;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic        lz_en = 1'b0;
  logic [7:0]  dp_mask = '0;
  wire         ready, overflow;
  wire  [7:0]  anode, cathode;

  int          checks = 0;
  int          errors = 0;
  int          ncyc;
  logic [31:0] disp_m = '0;

  logic [6:0] seg_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .value    (value),
    .load     (load),
    .mode     (mode),
    .lz_en    (lz_en),
    .dp_mask  (dp_mask),
    .ready    (ready),
    .overflow (overflow),
    .anode    (anode),
    .cathode  (cathode)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; the scan position is a pure function of it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic cmp_outputs();
    int p, nib;
    logic blank;
    logic [7:0] exp_an, exp_ca;
    p      = ((ncyc - 1) / CLK_DIV) % DIGITS;
    nib    = int'((disp_m >> (4 * p)) & 32'hF);
    blank  = lz_en && (p != 0) && ((disp_m >> (4 * p)) == 32'd0);
    exp_an = blank ? 8'hFF : ~(8'd1 << p);
    exp_ca = blank ? 8'hFF : ~{dp_mask[p], seg_ref[nib]};
    chk("anode", {24'd0, anode}, {24'd0, exp_an});
    chk("cathode", {24'd0, cathode}, {24'd0, exp_ca});
  endtask

  task automatic check_scan(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_outputs();
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic hex_load(input logic [31:0] v);
    @(negedge clk);
    chk("ready_idle", {31'd0, ready}, 32'd1);
    value = v; mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ready_after_hex", {31'd0, ready}, 32'd1);
    chk("ovf_hex", {31'd0, overflow}, 32'd0);
    disp_m = v;
    settle();
  endtask

  task automatic dec_load(input logic [31:0] v, input logic poke);
    int cnt;
    @(negedge clk);
    chk("ready_idle", {31'd0, ready}, 32'd1);
    value = v; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      if (poke && cnt == 5) begin
        value = 32'hFFFF_FFFF; mode = 1'b0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      cnt++;
      cmp_outputs();
    end
    load = 1'b0;
    chk("ready_low_cycles", cnt, 34);
    disp_m = to_bcd(v);
    chk("ovf_dec", {31'd0, overflow}, {31'd0, (v >= 32'd100000000)});
    settle();
  endtask

  initial begin
    logic [31:0] r;
    #12;
    chk("rst_anode", {24'd0, anode}, 32'h0000_00FF);
    chk("rst_cathode", {24'd0, cathode}, 32'h0000_00FF);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_first", {31'd0, ready}, 32'd1);
    settle();
    check_scan(36);

    // hex digits, each digit slot held CLK_DIV cycles
    hex_load(32'h1234_ABCD);
    check_scan(70);

    // wrap with decimal point on digit 0 only
    dp_mask = 8'h01;
    settle();
    check_scan(70);
    dp_mask = 8'h00;
    settle();

    dec_load(32'd12345678, 1'b0);
    check_scan(70);

    dec_load(32'd100000000, 1'b0);
    lz_en = 1'b1;
    settle();
    check_scan(70);

    hex_load(32'h0000_0050);
    check_scan(70);

    // a load arriving mid-conversion must be ignored
    lz_en = 1'b0;
    settle();
    dec_load(32'd87654321, 1'b1);
    check_scan(70);

    // reset in the middle of a conversion
    @(negedge clk);
    value = 32'd99999999; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_anode", {24'd0, anode}, 32'h0000_00FF);
    chk("mid_rst_cathode", {24'd0, cathode}, 32'h0000_00FF);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    disp_m = '0;
    chk("ready_after_rst", {31'd0, ready}, 32'd1);
    settle();
    check_scan(70);
    lz_en = 1'b1;
    settle();
    check_scan(36);

    for (int k = 0; k < 10; k++) begin
      lz_en   = 1'($urandom_range(0, 1));
      dp_mask = 8'($urandom);
      settle();
      r = $urandom;
      if (k % 3 == 0)      hex_load($urandom);
      else if (k % 3 == 1) dec_load($urandom_range(0, 99999999), 1'b0);
      else                 dec_load(r, 1'b0);
      check_scan(66);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed seven-segment digits (2..16).
REQ-002 SHALL have parameter CLK_DIV, default 100000, clock cycles per digit scan slot (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning anode and cathode outputs are asserted low when 1 and high when 0.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port value  input  4*DIGITS  binary or hex value to display.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing value and mode.
REQ-008 SHALL have port mode  input  1  0 = hex nibbles, 1 = unsigned decimal conversion.
REQ-009 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-010 SHALL have port dp_mask  input  DIGITS  decimal point per digit, live (not latched).
REQ-011 SHALL have port ready  output  1  high when load will be accepted.
REQ-012 SHALL have port overflow  output  1  last decimal value did not fit in DIGITS digits.
REQ-013 SHALL have port anode  output  DIGITS  one-hot digit select, polarity per ACTIVE_LOW.
REQ-014 SHALL have port cathode  output  8  segments {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.

Function
REQ-015 SHALL keep a prescaler counting 0..CLK_DIV-1; at count CLK_DIV-1 it wraps to 0 and issues a one-cycle tick.
REQ-016 SHALL advance a digit index on each tick, 0..DIGITS-1, wrapping DIGITS-1 -> 0.
REQ-017 SHALL drive anode asserted only at the current index bit, all others deasserted; registered, one cycle after index change.
REQ-018 SHALL decode the current digit's nibble via a fixed 0-F hex table to cathode[6:0], and cathode[7] from dp_mask[index].
REQ-019 SHALL, with lz_en=1, deassert all anodes for a digit whose nibble and all higher nibbles are zero, except digit 0 which is always lit.
REQ-020 SHALL implement FSM IDLE, CONV, COMMIT; ready=1 only in IDLE.
REQ-021 SHALL, in IDLE with load=1 and mode=0, copy value into the display register on the next edge, stay IDLE, and clear overflow.
REQ-022 SHALL, in IDLE with load=1 and mode=1, capture value and enter CONV.
REQ-023 SHALL, in CONV, perform one shift-add-3 (double-dabble) step per cycle for exactly 4*DIGITS cycles, then enter COMMIT.
REQ-024 SHALL set a sticky overflow flag during CONV whenever a 1 is shifted out of the top BCD digit.
REQ-025 SHALL, in COMMIT, write the BCD result (low DIGITS digits) into the display register and update overflow, then return to IDLE; load-to-display latency in decimal mode is 4*DIGITS+2 cycles.
REQ-026 SHALL ignore load while ready=0; no queueing.
REQ-027 SHALL continue scanning the previous display register contents unchanged during CONV.
REQ-028 SHALL show truncated low digits on overflow (no blanking or dashes).

Reset
REQ-029 SHALL, on reset low, asynchronously clear prescaler, index, display register, conversion state, overflow to 0, FSM to IDLE, and drive all anodes and cathodes deasserted.
REQ-030 SHALL abort an in-progress conversion on reset; no partial result committed.
REQ-031 SHALL assert ready=1 in the first cycle after reset release.

Structure
REQ-032 SHALL place the hex-to-segment table constants, FSM state encodings, and polarity helper in a shared package seg_pkg.
REQ-033 SHALL isolate the double-dabble engine in sub-module bin2bcd_seq (start, busy, done, bcd, overflow).
REQ-034 SHALL size prescaler and index counters by clog2 of CLK_DIV and DIGITS.

Verification
REQ-035 SHALL cover hex: DIGITS=8, CLK_DIV=4, load value=32'h1234ABCD mode=0 -> digit 0 cathode=8'hA1 (D, active-low), digit 7 shows 1, each anode held 4 cycles.
REQ-036 SHALL cover decimal: load 32'd12345678 mode=1 -> ready low 34 cycles, display 1,2,3,4,5,6,7,8, overflow=0.
REQ-037 SHALL cover overflow: load 32'd100000000 mode=1 -> display 00000000, overflow=1; with lz_en=1 only digit 0 lit.
REQ-038 SHALL cover blanking: hex 32'h00000050 lz_en=1 -> anodes for digits 2-7 never asserted, digits 0-1 scanned.
REQ-039 SHALL cover busy-load and mid-reset: second load during CONV ignored; reset asserted at cycle 10 of CONV -> all outputs deasserted, display zero, ready=1 after release.
REQ-040 SHALL cover wrap: index returns to 0 after digit 7 and dp_mask=8'h01 asserts cathode[7] only on digit 0.
